// File: rtl/adc_scan_pkg.sv
// Shared types and helpers for the ADC round-robin scan sequencer.
// Channel index width is fixed at 3 bits (up to 8 channels).
package adc_scan_pkg;

   localparam int CHAN_W     = 3;
   localparam int DEFAULT_DW = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_SCAN  = 2'd2
   } state_e;

   // Lowest set bit of mask; 0 when mask is empty.
   function automatic logic [CHAN_W-1:0] first_chan(input logic [7:0] mask);
      logic [CHAN_W-1:0] r;
      r = '0;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i]) r = CHAN_W'(i);
      end
      return r;
   endfunction

   // Highest set bit of mask; 0 when mask is empty.
   function automatic logic [CHAN_W-1:0] highest_chan(input logic [7:0] mask);
      logic [CHAN_W-1:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (mask[i]) r = CHAN_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/adc_scan_next_chan.sv
// Wrap-around priority picker: lowest enabled channel above cur_i, else lowest enabled.
// Purely combinational; a lone enabled channel picks itself.
module adc_scan_next_chan
   import adc_scan_pkg::*;
#(
   parameter int NCHAN = 2
) (
   input  logic [CHAN_W-1:0] cur_i,
   input  logic [NCHAN-1:0]  mask_i,
   output logic [CHAN_W-1:0] nxt_o
);

   logic [7:0] mask_ext;
   logic [7:0] above;

   assign mask_ext = 8'(mask_i);

   always_comb begin
      above = '0;
      for (int i = 0; i < 8; i++) begin
         above[i] = mask_ext[i] && (i > int'(cur_i));
      end
      if (above != 8'd0) nxt_o = first_chan(above);
      else               nxt_o = first_chan(mask_ext);
   end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Round-robin channel scheduler for the serial ADC driver; results land one frame late in a bank
// read through a 1-cycle registered port. ADC_SCAN_AVG_EN enables per-channel 2^AVG_LOG2 averaging.
module adc_scan_sequencer
   import adc_scan_pkg::*;
#(
   parameter int NCHAN = 2,
   parameter int DW    = DEFAULT_DW
`ifdef ADC_SCAN_AVG_EN
   ,parameter int AVG_LOG2 = 2
`endif
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              enable_i,
   input  logic [NCHAN-1:0]  chan_mask_i,
   input  logic              adc_ready_i,
   input  logic [DW-1:0]     adc_data_i,
   output logic [CHAN_W-1:0] adc_channel_o,
   input  logic [CHAN_W-1:0] rd_addr_i,
   output logic [DW-1:0]     rd_data_o,
   output logic [NCHAN-1:0]  res_valid_o,
   output logic              scan_done_o,
   output logic              busy_o
);

   state_e            state_q, state_d;
   logic              adc_ready_q, enable_q;
   logic [CHAN_W-1:0] chan_q, chan_d;
   logic [CHAN_W-1:0] tag_q, tag_d;
   logic              tag_vld_q, tag_vld_d;
   logic [DW-1:0]     bank_q [NCHAN];
   logic [NCHAN-1:0]  vld_q;
   logic              scan_done_q;
   logic [DW-1:0]     rd_data_q, rd_d;

   logic              fe, en_rise, mask_any, wr, commit;
   logic [CHAN_W-1:0] pick_cur, pick_nxt;
   logic [DW-1:0]     wr_dat;

   assign fe       = adc_ready_i & ~adc_ready_q;
   assign en_rise  = enable_i & ~enable_q;
   assign mask_any = |chan_mask_i;

   // One picker serves both the IDLE load (search from the top) and the per-frame step.
   assign pick_cur = (state_q == ST_IDLE) ? CHAN_W'(NCHAN - 1) : chan_q;

   adc_scan_next_chan #(.NCHAN(NCHAN)) u_next_chan (
      .cur_i  (pick_cur),
      .mask_i (chan_mask_i),
      .nxt_o  (pick_nxt)
   );

   always_comb begin
      state_d   = state_q;
      chan_d    = chan_q;
      tag_d     = tag_q;
      tag_vld_d = tag_vld_q;
      wr        = 1'b0;
      if (!enable_i) begin
         state_d   = ST_IDLE;
         tag_vld_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mask_any) begin
                  chan_d  = pick_nxt;
                  state_d = ST_PRIME;
               end
            end
            ST_PRIME: begin
               if (fe) begin
                  if (mask_any) begin
                     tag_d     = chan_q;
                     tag_vld_d = 1'b1;
                     chan_d    = pick_nxt;
                     state_d   = ST_SCAN;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_SCAN: begin
               if (fe) begin
                  wr = tag_vld_q;
                  if (mask_any) begin
                     tag_d  = chan_q;
                     chan_d = pick_nxt;
                  end else begin
                     state_d   = ST_IDLE;
                     tag_vld_d = 1'b0;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         adc_ready_q <= 1'b0;
         enable_q    <= 1'b0;
         chan_q      <= '0;
         tag_q       <= '0;
         tag_vld_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         adc_ready_q <= adc_ready_i;
         enable_q    <= enable_i;
         chan_q      <= chan_d;
         tag_q       <= tag_d;
         tag_vld_q   <= tag_vld_d;
      end
   end

`ifdef ADC_SCAN_AVG_EN
   localparam int AW = DW + AVG_LOG2;

   logic [AW-1:0]       acc_q [NCHAN];
   logic [AVG_LOG2-1:0] cnt_q [NCHAN];
   logic [AW-1:0]       acc_sel, acc_sum;
   logic [AVG_LOG2-1:0] cnt_sel;

   always_comb begin
      acc_sel = '0;
      cnt_sel = '0;
      for (int i = 0; i < NCHAN; i++) begin
         if (tag_q == CHAN_W'(i)) begin
            acc_sel = acc_q[i];
            cnt_sel = cnt_q[i];
         end
      end
   end

   assign acc_sum = acc_sel + AW'(adc_data_i);
   assign commit  = wr & (&cnt_sel);
   assign wr_dat  = acc_sum[AW-1:AVG_LOG2];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NCHAN; i++) begin
            acc_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else if (en_rise) begin
         for (int i = 0; i < NCHAN; i++) begin
            acc_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else if (wr) begin
         for (int i = 0; i < NCHAN; i++) begin
            if (tag_q == CHAN_W'(i)) begin
               if (&cnt_q[i]) begin
                  acc_q[i] <= '0;
                  cnt_q[i] <= '0;
               end else begin
                  acc_q[i] <= acc_sum;
                  cnt_q[i] <= cnt_q[i] + 1'b1;
               end
            end
         end
      end
   end
`else
   assign commit = wr;
   assign wr_dat = adc_data_i;
`endif

   // Out-of-range addresses match no entry and read as zero.
   always_comb begin
      rd_d = '0;
      for (int i = 0; i < NCHAN; i++) begin
         if (rd_addr_i == CHAN_W'(i)) rd_d = bank_q[i];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NCHAN; i++) bank_q[i] <= '0;
         vld_q       <= '0;
         scan_done_q <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         scan_done_q <= commit && (tag_q == highest_chan(8'(chan_mask_i)));
         rd_data_q   <= rd_d;
         if (en_rise) begin
            vld_q <= '0;
         end
         for (int i = 0; i < NCHAN; i++) begin
            if (commit && tag_q == CHAN_W'(i)) begin
               bank_q[i] <= wr_dat;
               vld_q[i]  <= 1'b1;
            end
         end
      end
   end

   assign adc_channel_o = chan_q;
   assign rd_data_o     = rd_data_q;
   assign res_valid_o   = vld_q;
   assign scan_done_o   = scan_done_q;
   assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
Round-robin channel scheduler for the adc082s021 serial ADC driver. It picks the channel for each SPI frame and follows the converter's one-frame pipeline: data returned in frame k belongs to the channel addressed in frame k-1. Each result is written to a per-channel register bank, which host logic reads through a registered port. It sits between the adc082s021 instance and the register/CSR layer.

Parameters:
NCHAN, 2, number of scannable channels (1..8); channel indices 0..NCHAN-1
DW, 12, width of adc_data and of stored results
AVG_LOG2, 2, log2 of samples averaged per result; used only with ADC_SCAN_AVG_EN

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  scan enable (level)
chan_mask  in  NCHAN  1 = channel takes part in the scan
adc_ready  in  1  driver ready level; its rising edge marks the end of a frame
adc_data  in  DW  driver data, valid while adc_ready is high
adc_channel  out  3  channel address driven to the driver for the next frame
rd_addr  in  3  result bank read address
rd_data  out  DW  result for rd_addr, registered, 1-cycle latency
res_valid  out  NCHAN  per-channel flag: result written since enable rose
scan_done  out  1  1-cycle pulse when the last enabled channel of a pass is written
busy  out  1  high in PRIME and SCAN

Behaviour:
- Reset (reset low, async): every output is 0, the bank is cleared, state IDLE, tag_valid=0.
- Frame event: fe = adc_ready high AND adc_ready_q low (adc_ready_q is adc_ready registered on clk). All actions below happen on the clk edge where fe is high.
- Timing of adc_channel: it changes only on an fe edge, so it is stable before the next frame begins (the driver samples it at frame start).
- Next channel: nxt(c) is the lowest-indexed enabled channel above c; if none exists, it wraps to the lowest enabled channel. If c is the only enabled channel, nxt(c)=c.
- States:
  - IDLE: busy=0. When enable=1 and chan_mask!=0, load adc_channel=nxt(NCHAN-1), i.e. the first enabled channel, and go to PRIME.
  - PRIME: on fe, discard adc_data (stale, belongs to an unknown channel); tag<=adc_channel; tag_valid<=1; adc_channel<=nxt(adc_channel); go to SCAN.
  - SCAN: on fe, bank[tag]<=adc_data; res_valid[tag]<=1; tag<=adc_channel; adc_channel<=nxt(adc_channel).
  - scan_done pulses in the cycle after a write where tag is the highest enabled channel.
- enable falls (any state): go to IDLE the next cycle; tag_valid<=0; bank and res_valid are kept. A frame in flight when enable falls is discarded.
- enable rising from IDLE clears res_valid.
- chan_mask changes: take effect at the next nxt() evaluation. A write already tagged still lands, even if that channel is now masked.
- chan_mask becomes 0 in PRIME or SCAN: finish the pending write on the next fe, then go to IDLE.
- rd_addr >= NCHAN: rd_data=0.
- fe in the same cycle enable falls: enable wins and nothing is written.

Optional Feature:
ADC_SCAN_AVG_EN
- Defined: each channel keeps an accumulator of DW+AVG_LOG2 bits and a counter of AVG_LOG2 bits. A write adds adc_data to the accumulator. After 2^AVG_LOG2 writes, bank[ch]<=acc>>AVG_LOG2 (truncating), the accumulator and counter clear, and res_valid/scan_done update. scan_done is tied to the pass in which the last enabled channel's bank entry updates. enable rising clears all accumulators.
- Undefined: each write goes straight to the bank as described above; no accumulators are built.

Decomposition:
- Package adc_scan_pkg holds: CHAN_W=3, DEFAULT_DW=12, the state encoding (IDLE, PRIME, SCAN), and a function or constant for the first-enabled search.
- One sub-module, adc_scan_next_chan: combinational wrap-around priority picker (cur, mask) -> nxt. It is reused by the IDLE load and the PRIME/SCAN steps.

Test Plan:
Bench uses a driver stub that returns data = 12'h100*ch + frame# for the channel addressed in the previous frame.
1. Reset low mid-SCAN -> outputs and bank become 0 immediately (async), state IDLE, adc_channel=0.
2. NCHAN=2, mask=2'b11, enable=1, 5 frames -> adc_channel sequence 0,1,0,1,0; frame 1 discarded; bank[0]=12'h001, bank[1]=12'h102, bank[0]=12'h003, bank[1]=12'h104; scan_done after the frame-3 and frame-5 writes; res_valid=2'b11.
3. mask=2'b10 only -> adc_channel held at 1; after frame 2, bank[1]=12'h101; scan_done every frame from then on.
4. enable dropped mid-frame then re-raised -> the in-flight frame is not written, res_valid=0 after re-enable, PRIME discards one frame again, bank keeps its old values until overwritten.
5. Mask changed from 2'b11 to 2'b01 mid-scan -> the pending write to ch1 lands, after which adc_channel stays at 0. Reading rd_addr=5 returns rd_data=0 one cycle later.
6. ADC_SCAN_AVG_EN, AVG_LOG2=2, ch0 samples 10,20,30,41 -> bank[0]=25 after the 4th write, not before.
